vx_gbar_responder: RTL and testbench
====================================

// Module: vx_gbar_responder
// PURPOSE
//  Responder end of the global-barrier bus.
//  - Accepts one barrier-arrival request per cycle from the cluster's core-side request channel.
//  - Tracks per-barrier arrivals across cores.
//  - When the last expected core arrives, broadcasts a one-cycle release response to all cores.
//  - Sits at cluster level, opposite every core scheduler's global-barrier request master.
// PARAMETERS
//  NUM_CORES     4  cores sharing this responder; NC_WIDTH = max(1,$clog2(NUM_CORES))
//  NUM_BARRIERS  4  barrier ids tracked;          NB_WIDTH = max(1,$clog2(NUM_BARRIERS))
// PORTS
//  clk              in   1         clock
//  reset_n          in   1         reset, synchronous, active-low
//  req_valid        in   1         arrival request valid
//  req_ready        out  1         responder can accept request
//  req_id           in   NB_WIDTH  barrier id
//  req_size_m1      in   NC_WIDTH  participating cores minus one
//  req_core_id      in   NC_WIDTH  arriving core
//  rsp_valid        out  1         release pulse, broadcast, no backpressure
//  rsp_id           out  NB_WIDTH  released barrier id
//  perf_releases    out  32        releases issued (GBAR_PERF_EN only)
//  perf_wait_cycles out  32        cycles with >=1 barrier open (GBAR_PERF_EN only)
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset_n is synchronous and active-low; sampled at posedge clk only.
//  - Reset state: all counters 0, all masks 0; rsp_valid=0, rsp_id=0, req_ready=0, perf counters 0.
//  - req_ready: goes 1 on the first cycle after reset_n deasserts, and stays 1 until the next reset.
//  - Fire: a request fires when req_valid && req_ready.
//  - Per-barrier state b:
//    - ctr[b]: NC_WIDTH, arrivals so far.
//    - mask[b]: NUM_CORES bits, cores arrived.
//  - On fire with id=b:
//    - Duplicate (mask[b][core_id] already 1): ignored, with no state change. Simulation error is flagged.
//    - Release case (ctr[b] == req_size_m1):
//      - ctr[b] <= 0, mask[b] <= 0.
//      - Next cycle: rsp_valid=1, rsp_id=b.
//    - Otherwise: ctr[b] <= ctr[b]+1, mask[b][core_id] <= 1.
//  - Latency: the release response appears exactly 1 cycle after the last arrival fires. It is registered.
//  - rsp_valid pulse: high for exactly one cycle per release. rsp_id holds its last value while rsp_valid=0.
//  - size_m1=0: the single arrival releases immediately (1-cycle latency), and no state is retained.
//  - Arrival on b in the cycle rsp_valid is high for b: counts toward a new epoch of b, because state was already cleared.
//  - Back-to-back releases on different ids: consecutive rsp pulses, one per cycle.
//  - size_m1 is taken from each request. A mismatch with the first arrival of the epoch flags a simulation error. The current request's value is still used for the compare.
//  - Arithmetic: ctr never exceeds NUM_CORES-1. An increment past that is a simulation error (it cannot occur with legal traffic).
//  - Reset mid-operation: all open barriers are discarded. A pending rsp pulse is dropped (rsp_valid=0 in the reset cycle).
// CONFIGURATION
//  GBAR_PERF_EN defined:
//    - perf_releases increments on each rsp_valid pulse.
//    - perf_wait_cycles increments each cycle in which any mask[b]!=0.
//    - Both counters wrap modulo 2^32.
//  GBAR_PERF_EN undefined: both perf ports tie to 0 and no counter flops exist.
// STRUCTURE
//  - VX_gpu_pkg holds gbar_req_data_t {id, size_m1, core_id} and gbar_rsp_data_t {id}. These are shared with the core-side requester.
//  - VX_gpu_pkg also holds the NB_WIDTH/NC_WIDTH derivations.
//  - One sub-module, vx_gbar_slot, is instantiated NUM_BARRIERS times.
//    - Holds ctr/mask.
//    - Inputs: arrive, core_id, size_m1.
//    - Outputs: release, open.
//  - Top level:
//    - decodes req_id to a slot;
//    - ORs the slot releases into the rsp register;
//    - holds the perf counters.
// TESTING
//  - Reset: reset_n=0 for 3 cycles -> rsp_valid=0, req_ready=0; 1 cycle after release -> req_ready=1.
//  - Full barrier: id=2, size_m1=3, cores 0..3 one per cycle -> no rsp after cores 0-2. rsp_valid=1, rsp_id=2 one cycle after core 3 fires, for 1 cycle only.
//  - Trivial: id=1, size_m1=0, core 2 -> rsp_id=1 next cycle.
//  - Interleave, with size_m1=1 on both ids:
//    - Stimulus: id0 core0, id1 core0, id1 core1, id0 core1.
//    - Required: rsp_id=1 then rsp_id=0, each 1 cycle after its last arrival.
//  - Duplicate: id3, size_m1=1.
//    - Stimulus: core0 arrives twice, then core1.
//    - Required: release only after core1; the duplicate is flagged and does not release.
//  - Reset mid-flight, then perf:
//    - Reset part: 2 of 4 arrivals on id0, then reset. Then 4 fresh arrivals -> release after the 4th, not the 2nd.
//    - Perf part (GBAR_PERF_EN): perf_releases=1; perf_wait_cycles equals the open-cycle count.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared global-barrier types and width derivations, common to the core-side requester and the cluster responder.
package VX_gpu_pkg;

  localparam int GBAR_NUM_CORES    = 4;
  localparam int GBAR_NUM_BARRIERS = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NC_WIDTH = clog2_min1(GBAR_NUM_CORES);
  localparam int NB_WIDTH = clog2_min1(GBAR_NUM_BARRIERS);

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_data_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_data_t;

endpackage

// File: rtl/vx_gbar_slot.sv
// One barrier id: arrival counter plus arrived-core mask; release_o is combinational on the final arrival.
module vx_gbar_slot
  import VX_gpu_pkg::*;
#(
  parameter int NUM_CORES = GBAR_NUM_CORES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arrive_i,
  input  logic [NC_WIDTH-1:0] core_id_i,
  input  logic [NC_WIDTH-1:0] size_m1_i,
  output logic                release_o,
  output logic                open_o
);

  localparam logic [NC_WIDTH-1:0] CTR_ONE = 1;
  localparam logic [NC_WIDTH-1:0] CTR_MAX = NUM_CORES - 1;

  logic [NC_WIDTH-1:0]  ctr_q, ctr_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NC_WIDTH-1:0]  size_q, size_d;
  logic                 dup;
  logic                 last;

  assign dup       = mask_q[core_id_i];
  assign last      = (ctr_q == size_m1_i);
  assign release_o = arrive_i && !dup && last;
  assign open_o    = |mask_q;

  always_comb begin
    ctr_d  = ctr_q;
    mask_d = mask_q;
    size_d = size_q;
    if (arrive_i && !dup) begin
      if (last) begin
        ctr_d  = '0;
        mask_d = '0;
      end else begin
        ctr_d             = ctr_q + CTR_ONE;
        mask_d[core_id_i] = 1'b1;
        // Remember the epoch's first size only to cross-check later arrivals.
        if (!open_o) size_d = size_m1_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctr_q  <= '0;
      mask_q <= '0;
      size_q <= '0;
    end else begin
      ctr_q  <= ctr_d;
      mask_q <= mask_d;
      size_q <= size_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && arrive_i) begin
      assert (!dup)
        else $warning("gbar: duplicate arrival from core %0d ignored", core_id_i);
      assert (!open_o || dup || size_m1_i == size_q)
        else $warning("gbar: size_m1 %0d differs from epoch value %0d", size_m1_i, size_q);
      assert (dup || last || ctr_q != CTR_MAX)
        else $warning("gbar: arrival counter overflow");
    end
  end

endmodule

// File: rtl/vx_gbar_responder.sv
// Cluster-level global-barrier responder: one arrival per cycle, registered one-cycle release broadcast.
// Optional GBAR_PERF_EN adds release and open-cycle counters; otherwise the perf ports are tied to zero.
module vx_gbar_responder
  import VX_gpu_pkg::*;
#(
  parameter int NUM_CORES    = GBAR_NUM_CORES,
  parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NB_WIDTH-1:0] req_id,
  input  logic [NC_WIDTH-1:0] req_size_m1,
  input  logic [NC_WIDTH-1:0] req_core_id,
  output logic                rsp_valid,
  output logic [NB_WIDTH-1:0] rsp_id,
  output logic [31:0]         perf_releases,
  output logic [31:0]         perf_wait_cycles
);

  gbar_req_data_t          req;
  gbar_rsp_data_t          rsp_q, rsp_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    ready_q;
  logic                    req_fire;
  logic [NUM_BARRIERS-1:0] slot_arrive;
  logic [NUM_BARRIERS-1:0] slot_release;
  logic [NUM_BARRIERS-1:0] slot_open;

  assign req       = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};
  assign req_fire  = req_valid && ready_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
    assign slot_arrive[b] = req_fire && (req.id == NB_WIDTH'(b));

    vx_gbar_slot #(
      .NUM_CORES (NUM_CORES)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .arrive_i  (slot_arrive[b]),
      .core_id_i (req.core_id),
      .size_m1_i (req.size_m1),
      .release_o (slot_release[b]),
      .open_o    (slot_open[b])
    );
  end

  // Only the addressed slot can release, so the id comes straight from the request.
  always_comb begin
    rsp_valid_d = |slot_release;
    rsp_d       = rsp_q;
    if (rsp_valid_d) rsp_d.id = req.id;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      ready_q     <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

`ifdef GBAR_PERF_EN
  logic [31:0] perf_rel_q, perf_rel_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_rel_d  = perf_rel_q + {31'd0, rsp_valid_q};
    perf_wait_d = perf_wait_q + {31'd0, |slot_open};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_rel_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_rel_q  <= perf_rel_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_releases    = perf_rel_q;
  assign perf_wait_cycles = perf_wait_q;
`else
  logic unused_open;
  assign unused_open      = |slot_open;
  assign perf_releases    = '0;
  assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_gbar_responder.sv
// Directed bench for vx_gbar_responder; expected values are hand-computed per vector.
module tb_vx_gbar_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_id;
  logic [1:0]  req_size_m1;
  logic [1:0]  req_core_id;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] perf_releases;
  logic [31:0] perf_wait_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vx_gbar_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_id           (req_id),
    .req_size_m1      (req_size_m1),
    .req_core_id      (req_core_id),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
    .perf_releases    (perf_releases),
    .perf_wait_cycles (perf_wait_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one arrival for one cycle, then check the registered response.
  task automatic send(input string tag, input logic [1:0] id, input logic [1:0] size_m1,
                      input logic [1:0] core, input logic exp_v, input logic [1:0] exp_id);
    req_valid   = 1'b1;
    req_id      = id;
    req_size_m1 = size_m1;
    req_core_id = core;
    tick();
    chk({tag, ".vld"}, {31'd0, rsp_valid}, {31'd0, exp_v});
    if (exp_v) chk({tag, ".id"}, {30'd0, rsp_id}, {30'd0, exp_id});
  endtask

  task automatic idle(input string tag, input logic [1:0] hold_id);
    req_valid = 1'b0;
    tick();
    chk({tag, ".vld"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".hold"}, {30'd0, rsp_id}, {30'd0, hold_id});
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_id      = '0;
    req_size_m1 = '0;
    req_core_id = '0;
    #2;
    repeat (3) tick();
    chk("rst.vld",   {31'd0, rsp_valid}, 32'd0);
    chk("rst.rdy",   {31'd0, req_ready}, 32'd0);
    chk("rst.id",    {30'd0, rsp_id},    32'd0);
    chk("rst.prel",  perf_releases,      32'd0);
    chk("rst.pwait", perf_wait_cycles,   32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst.rdy1",  {31'd0, req_ready}, 32'd1);

    // Full barrier on id 2, all four cores
    send("full0", 2'd2, 2'd3, 2'd0, 1'b0, 2'd0);
    send("full1", 2'd2, 2'd3, 2'd1, 1'b0, 2'd0);
    send("full2", 2'd2, 2'd3, 2'd2, 1'b0, 2'd0);
    send("full3", 2'd2, 2'd3, 2'd3, 1'b1, 2'd2);
    idle("full.end", 2'd2);

    // Single-core barrier releases at once
    send("triv", 2'd1, 2'd0, 2'd2, 1'b1, 2'd1);
    idle("triv.end", 2'd1);

    // Interleaved ids, back-to-back releases
    send("ilv0", 2'd0, 2'd1, 2'd0, 1'b0, 2'd0);
    send("ilv1", 2'd1, 2'd1, 2'd0, 1'b0, 2'd0);
    send("ilv2", 2'd1, 2'd1, 2'd1, 1'b1, 2'd1);
    send("ilv3", 2'd0, 2'd1, 2'd1, 1'b1, 2'd0);
    idle("ilv.end", 2'd0);

    // Duplicate arrival must not count
    send("dup0", 2'd3, 2'd1, 2'd0, 1'b0, 2'd0);
    send("dup1", 2'd3, 2'd1, 2'd0, 1'b0, 2'd0);
    send("dup2", 2'd3, 2'd1, 2'd1, 1'b1, 2'd3);
    idle("dup.end", 2'd3);

    // Arrival during the release pulse starts a fresh epoch
    send("ep0", 2'd2, 2'd1, 2'd0, 1'b0, 2'd0);
    send("ep1", 2'd2, 2'd1, 2'd1, 1'b1, 2'd2);
    send("ep2", 2'd2, 2'd1, 2'd0, 1'b0, 2'd0);
    send("ep3", 2'd2, 2'd1, 2'd1, 1'b1, 2'd2);
    idle("ep.end", 2'd2);

    // Reset mid-flight discards open state and any would-be release
    send("mid0", 2'd0, 2'd3, 2'd0, 1'b0, 2'd0);
    send("mid1", 2'd0, 2'd3, 2'd1, 1'b0, 2'd0);
    reset_n     = 1'b0;
    req_valid   = 1'b1;
    req_id      = 2'd1;
    req_size_m1 = 2'd0;
    req_core_id = 2'd0;
    tick();
    chk("mid.rst.vld", {31'd0, rsp_valid}, 32'd0);
    chk("mid.rst.rdy", {31'd0, req_ready}, 32'd0);
    chk("mid.rst.prel", perf_releases, 32'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
    chk("mid.rdy", {31'd0, req_ready}, 32'd1);
    send("fresh0", 2'd0, 2'd3, 2'd0, 1'b0, 2'd0);
    send("fresh1", 2'd0, 2'd3, 2'd1, 1'b0, 2'd0);
    send("fresh2", 2'd0, 2'd3, 2'd2, 1'b0, 2'd0);
    send("fresh3", 2'd0, 2'd3, 2'd3, 1'b1, 2'd0);
    idle("fresh.end", 2'd0);

`ifdef GBAR_PERF_EN
    chk("perf.rel",  perf_releases,    32'd1);
    chk("perf.wait", perf_wait_cycles, 32'd3);
`else
    chk("perf.rel",  perf_releases,    32'd0);
    chk("perf.wait", perf_wait_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
